// File: rtl/rom_reader_pkg.sv
// Shared types and constants for the ROM frame reader.
//   state_t     : reader FSM states
//   FIFO_DEPTH  : skid FIFO depth (must cover RD_LATENCY+2 for full rate)
//   FIFO_PTR_W  : FIFO pointer width
//   FIFO_CNT_W  : FIFO occupancy counter width (0..FIFO_DEPTH)
//   tag_t       : frame markers carried alongside each sample
package rom_reader_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } state_t;

  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned FIFO_PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned FIFO_CNT_W = FIFO_PTR_W + 1;

  typedef struct packed {
    logic sof;
    logic eof;
  } tag_t;

endpackage

// File: rtl/rom_reader_skid_fifo.sv
// Small synchronous FIFO of {tag, data} absorbing ROM returns while the
// downstream stalls. Depth fixed by FIFO_DEPTH (power of two).
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   push, wr_tag,
//   wr_data        : write side (ignored when full)
//   pop            : read side advance (ignored when empty)
//   rd_tag, rd_data: head entry (meaningful only when count != 0)
//   count          : current occupancy
module rom_reader_skid_fifo
  import rom_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  tag_t                  wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  pop,
  output tag_t                  rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic [FIFO_CNT_W-1:0] count
);

  tag_t                  tag_mem  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [FIFO_DEPTH];
  logic [FIFO_PTR_W-1:0] wr_ptr;
  logic [FIFO_PTR_W-1:0] rd_ptr;
  logic                  wr_ok;
  logic                  rd_ok;

  always_comb begin
    wr_ok = push && (count != FIFO_CNT_W'(FIFO_DEPTH));
    rd_ok = pop && (count != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) begin
        tag_mem[wr_ptr]  <= wr_tag;
        data_mem[wr_ptr] <= wr_data;
        wr_ptr           <= wr_ptr + FIFO_PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + FIFO_PTR_W'(1);
      end
      count <= count + FIFO_CNT_W'(wr_ok) - FIFO_CNT_W'(rd_ok);
    end
  end

  always_comb begin
    rd_tag  = tag_mem[rd_ptr];
    rd_data = data_mem[rd_ptr];
  end

endmodule

// File: rtl/rom_frame_reader.sv
// Sweeps the waveform ROM address bus to read one or more 2**ADDR_WIDTH
// sample frames, hides the ROM read latency behind a credit-limited skid
// FIFO and presents the samples on a valid/ready stream with frame markers.
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   start, stop  : run control pulses (stop ends at the next frame boundary)
//   busy, done   : run status; done pulses once when the run has drained
//   rom_addr, rom_rd_en, rom_rd_data : single-port ROM interface
//   m_valid, m_ready, m_data, m_sof, m_eof : sample stream
// Build option: define ROM_READER_SIGNED_EN to convert offset-binary ROM
// words to two's complement (MSB inverted) as they enter the FIFO.
module rom_frame_reader
  import rom_reader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 7,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned NUM_FRAMES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  output logic                  rom_rd_en,
  input  logic [DATA_WIDTH-1:0] rom_rd_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_sof,
  output logic                  m_eof
);

  localparam int unsigned FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

  state_t                  state;
  state_t                  state_nxt;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [FRAME_W-1:0]      frame_cnt;
  logic                    stop_pending;

  // Read-return delay line: one stage per cycle of ROM latency.
  logic [RD_LATENCY-1:0]   dl_en;
  logic [RD_LATENCY-1:0]   dl_sof;
  logic [RD_LATENCY-1:0]   dl_eof;

  logic [FIFO_CNT_W-1:0]   inflight;
  logic [FIFO_CNT_W-1:0]   fifo_count;
  logic [FIFO_CNT_W:0]     occupancy;
  logic                    credit_ok;
  logic                    at_last;
  logic                    last_frame;
  logic                    end_run;

  tag_t                    fifo_wr_tag;
  logic [DATA_WIDTH-1:0]   fifo_wr_data;
  tag_t                    fifo_rd_tag;
  logic [DATA_WIDTH-1:0]   fifo_rd_data;
  logic                    fifo_pop;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + FIFO_CNT_W'(dl_en[i]);
    end
  end

  // Reads already in the delay line own a FIFO slot, so counting them keeps
  // the FIFO from overflowing no matter how long m_ready stays low.
  always_comb begin
    occupancy  = {1'b0, fifo_count} + {1'b0, inflight};
    credit_ok  = occupancy < (FIFO_CNT_W + 1)'(FIFO_DEPTH);
    at_last    = (addr == '1);
    last_frame = (NUM_FRAMES != 0) && (frame_cnt == FRAME_W'(NUM_FRAMES - 1));
    end_run    = at_last && (stop_pending || stop || last_frame);
  end

  always_comb begin
    state_nxt = state;
    rom_rd_en = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (credit_ok) begin
          rom_rd_en = 1'b1;
          if (end_run) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if ((fifo_count == '0) && (inflight == '0)) begin
          done      = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      addr         <= '0;
      frame_cnt    <= '0;
      stop_pending <= 1'b0;
      dl_en        <= '0;
      dl_sof       <= '0;
      dl_eof       <= '0;
    end else begin
      state     <= state_nxt;
      dl_en[0]  <= rom_rd_en;
      dl_sof[0] <= rom_rd_en && (addr == '0);
      dl_eof[0] <= rom_rd_en && at_last;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        dl_en[i]  <= dl_en[i-1];
        dl_sof[i] <= dl_sof[i-1];
        dl_eof[i] <= dl_eof[i-1];
      end
      case (state)
        IDLE: begin
          // A stop arriving with the start is dropped along with any stale one.
          if (start) begin
            frame_cnt    <= '0;
            stop_pending <= 1'b0;
          end
        end
        ISSUE: begin
          if (stop) stop_pending <= 1'b1;
          if (rom_rd_en) begin
            addr <= addr + ADDR_WIDTH'(1);
            if (at_last) frame_cnt <= frame_cnt + FRAME_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    fifo_wr_tag.sof = dl_sof[RD_LATENCY-1];
    fifo_wr_tag.eof = dl_eof[RD_LATENCY-1];
`ifdef ROM_READER_SIGNED_EN
    fifo_wr_data = {~rom_rd_data[DATA_WIDTH-1], rom_rd_data[DATA_WIDTH-2:0]};
`else
    fifo_wr_data = rom_rd_data;
`endif
  end

  rom_reader_skid_fifo #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (dl_en[RD_LATENCY-1]),
    .wr_tag  (fifo_wr_tag),
    .wr_data (fifo_wr_data),
    .pop     (fifo_pop),
    .rd_tag  (fifo_rd_tag),
    .rd_data (fifo_rd_data),
    .count   (fifo_count)
  );

  // Stream outputs are forced to zero while the FIFO is empty.
  always_comb begin
    m_valid  = (fifo_count != '0);
    m_data   = m_valid ? fifo_rd_data : '0;
    m_sof    = m_valid && fifo_rd_tag.sof;
    m_eof    = m_valid && fifo_rd_tag.eof;
    fifo_pop = m_valid && m_ready;
    busy     = (state != IDLE);
    rom_addr = addr;
  end

endmodule

// File: doc/rom_frame_reader.md
Name: rom_frame_reader

Overview:
- Reads one or more 128-sample frames from the waveform ROM (e.g. the triangle-wave table) by sweeping its address bus.
- Compensates the ROM read latency and presents samples on a valid/ready stream with frame markers, for the FFT input stage.
- Sits between the single-port waveform ROM IP (addr / rd_data / clk / rst) and the FFT core's sample input.

Parameters:
- ADDR_WIDTH, 7, ROM address width; frame length = 2**ADDR_WIDTH samples.
- DATA_WIDTH, 8, ROM / sample data width.
- RD_LATENCY, 1, ROM address-to-data latency in cycles; legal 1 (no output reg) or 2 (output reg).
- NUM_FRAMES, 1, frames per start command; 0 = continuous until stop.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- start  in  1  one-cycle pulse; begins a run when idle
- stop  in  1  one-cycle pulse; ends the run at the next frame boundary
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last sample of the run is accepted
- rom_addr  out  ADDR_WIDTH  ROM address
- rom_rd_en  out  1  read issued this cycle
- rom_rd_data  in  DATA_WIDTH  ROM data, valid RD_LATENCY cycles after rom_rd_en
- m_valid  out  1  stream data valid
- m_ready  in  1  downstream accept
- m_data  out  DATA_WIDTH  sample
- m_sof  out  1  marks sample at address 0
- m_eof  out  1  marks sample at address 2**ADDR_WIDTH-1

Behaviour:
- Clocking and reset: one clock, clk. Reset is synchronous and active-high on rst, and dominates all other inputs.
- Reset values: busy=0, done=0, rom_rd_en=0, rom_addr=0, m_valid=0, m_data=0, m_sof=0, m_eof=0. FIFO and in-flight counters are cleared; FSM goes to IDLE.
- Reset mid-run discards all in-flight and buffered samples. No done pulse is generated.
- FSM states:
  - IDLE: start moves to ISSUE; busy goes high the next cycle. start while busy is ignored.
  - ISSUE: issues reads while credit is available.
  - DRAIN: entered after the last address of the last frame is issued. Waits for FIFO empty and in-flight=0, then moves to IDLE with done=1 for one cycle.
- Read credit:
  - Skid FIFO depth DEPTH=4 (>= RD_LATENCY+2).
  - rom_rd_en=1 only when fifo_count + inflight < DEPTH.
  - This guarantees no overflow under arbitrary m_ready backpressure.
- Address:
  - rom_addr increments by 1 per issued read.
  - It wraps 2**ADDR_WIDTH-1 -> 0, and a wrap ends a frame.
  - The frame counter increments on each wrap.
  - With NUM_FRAMES>0, the run ends after NUM_FRAMES wraps.
- Stop handling:
  - stop sets a pending flag; issuing ceases after the current frame's last address, then the FSM goes to DRAIN.
  - stop in IDLE is ignored.
  - start and stop in the same cycle while IDLE: start wins and the stop is discarded.
- Read-return capture:
  - A delay line of RD_LATENCY stages carries {rd_en, sof, eof} alongside each read.
  - rom_rd_data is written into the FIFO, with its tags, when the delayed rd_en is high.
- Output:
  - m_data / m_sof / m_eof come from the FIFO head.
  - m_valid = FIFO not empty.
  - Data is held stable while m_valid && !m_ready.
  - Pop occurs on m_valid && m_ready; a push and pop in the same cycle is legal.
- Throughput: with m_ready held high, one sample per cycle after initial latency.
- Latency: start -> first m_valid = RD_LATENCY+2 cycles.

Optional Feature:
- Macro: ROM_READER_SIGNED_EN.
- Defined: m_data = rom_rd_data with MSB inverted. This converts offset-binary ROM content (0x80 = midscale) to two's complement for the FFT. The conversion is applied at FIFO write.
- Undefined: m_data passes ROM content unchanged.

Decomposition:
- Package rom_reader_pkg holds:
  - FSM state enum {IDLE, ISSUE, DRAIN}
  - FIFO_DEPTH=4 and its pointer width
  - tag struct {sof, eof}
- Sub-module rom_reader_skid_fifo: a DEPTH-entry synchronous FIFO of {tag, data} with count output. Same clk/rst convention.

Test Plan:
- Single frame, m_ready=1: ROM model holds data=addr (latency 1) -> 128 beats with m_data 0x00..0x7F in order; m_sof on beat 0, m_eof on beat 127; done one cycle after beat 127 accepted; busy low after.
- Backpressure: m_ready toggles 1-0-1-0, then is held low 20 cycles -> no sample lost or duplicated; m_data stable while stalled; fifo_count never exceeds 4.
- RD_LATENCY=2, NUM_FRAMES=3 -> 384 beats; m_sof at beats 0/128/256, m_eof at 127/255/383; exactly one done.
- NUM_FRAMES=0 with stop pulsed at sample 40 of frame 1 -> stream finishes frame 1 (ends at 0x7F), then done; no sample of frame 2 emitted.
- rst asserted mid-frame at sample 60 -> next cycle all outputs at reset values, no done; a new start re-emits from address 0 with m_sof.
- ROM_READER_SIGNED_EN defined, ROM word 0x80 -> m_data=0x00; word 0x00 -> 0x80; word 0xFF -> 0x7F.
